// File: rtl/bridge_decode_if.sv
// rtl/bridge_decode_if.sv - host/slave bus bundle for the bridge address decoder
//
// Purpose: groups the host request/return signals and the slave fan-out signals.
// Ports (signals):
//   addr, wr, rd, wr_data   host request
//   rd_data, rd_valid       host read return
//   s_addr, s_wr_data       registered request, common to all slaves
//   s_wr, s_rd              one-hot slave strobes
//   s_rd_data               slave read data, slave i at [32*i +: 32]
// Modports: slave = decoder side, master = host plus slave-array side.
interface bridge_decode_if #(
    parameter int NUM_SLAVES = 4
);
    logic [31:0]              addr;
    logic                     wr;
    logic                     rd;
    logic [31:0]              wr_data;
    logic [31:0]              rd_data;
    logic                     rd_valid;
    logic [31:0]              s_addr;
    logic [31:0]              s_wr_data;
    logic [NUM_SLAVES-1:0]    s_wr;
    logic [NUM_SLAVES-1:0]    s_rd;
    logic [32*NUM_SLAVES-1:0] s_rd_data;

    modport slave (
        input  addr, wr, rd, wr_data, s_rd_data,
        output rd_data, rd_valid, s_addr, s_wr_data, s_wr, s_rd
    );

    modport master (
        output addr, wr, rd, wr_data, s_rd_data,
        input  rd_data, rd_valid, s_addr, s_wr_data, s_wr, s_rd
    );
endinterface

// File: rtl/bridge_decode.sv
// rtl/bridge_decode.sv - address decoder and latency-matched read-return mux
//
// Purpose: registers the host request, fans it out to the slave picked by
// addr[SEL_LSB +: SEL_W], and returns that slave's read data RD_LATENCY+2
// cycles after the host read strobe. Unmapped reads return DEFAULT_DATA.
// Ports:
//   clk      bridge clock
//   reset_n  asynchronous active-low reset
//   bus      bridge_decode_if.slave (host request/return and slave fan-out)
module bridge_decode #(
    parameter int          NUM_SLAVES   = 4,
    parameter int          SEL_LSB      = 24,
    parameter int          SEL_W        = 2,
    parameter int          RD_LATENCY   = 1,
    parameter logic [31:0] DEFAULT_DATA = 32'hDEAD_BEEF
) (
    input  logic            clk,
    input  logic            reset_n,
    bridge_decode_if.slave  bus
);
    // One stage to register the request plus RD_LATENCY stages matching the slave.
    localparam int DEPTH = 1 + RD_LATENCY;
    // One extra bit so NUM_SLAVES == 2**SEL_W still compares correctly.
    localparam logic [SEL_W:0] NUM_SEL = (SEL_W + 1)'(NUM_SLAVES);

    logic [SEL_W-1:0] sel;
    logic             mapped;

    assign sel    = bus.addr[SEL_LSB +: SEL_W];
    assign mapped = ({1'b0, sel} < NUM_SEL);

    logic [31:0]                   s_addr_q,    s_addr_d;
    logic [31:0]                   s_wr_data_q, s_wr_data_d;
    logic [NUM_SLAVES-1:0]         s_wr_q,      s_wr_d;
    logic [NUM_SLAVES-1:0]         s_rd_q,      s_rd_d;
    logic [DEPTH-1:0]              pv_q,        pv_d;
    logic [DEPTH-1:0]              pm_q,        pm_d;
    logic [DEPTH-1:0][SEL_W-1:0]   ps_q,        ps_d;
    logic [31:0]                   rd_data_q,   rd_data_d;
    logic                          rd_valid_q,  rd_valid_d;
    logic [31:0]                   ret_data;

    always_comb begin
        s_addr_d    = bus.addr;
        s_wr_data_d = bus.wr_data;
        s_wr_d      = '0;
        s_rd_d      = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (mapped && sel == i[SEL_W-1:0]) begin
                s_wr_d[i] = bus.wr;
                s_rd_d[i] = bus.rd;
            end
        end

        // Unmapped reads still travel the pipeline so they return in order.
        pv_d = {pv_q[DEPTH-2:0], bus.rd};
        pm_d = {pm_q[DEPTH-2:0], mapped};
        ps_d = {ps_q[DEPTH-2:0], sel};

        // The oldest stage lines up with the cycle the slave data is valid.
        ret_data = DEFAULT_DATA;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (pm_q[DEPTH-1] && ps_q[DEPTH-1] == i[SEL_W-1:0]) begin
                ret_data = bus.s_rd_data[32*i +: 32];
            end
        end

        rd_valid_d = pv_q[DEPTH-1];
        rd_data_d  = pv_q[DEPTH-1] ? ret_data : rd_data_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_addr_q    <= '0;
            s_wr_data_q <= '0;
            s_wr_q      <= '0;
            s_rd_q      <= '0;
            pv_q        <= '0;
            pm_q        <= '0;
            ps_q        <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
        end else begin
            s_addr_q    <= s_addr_d;
            s_wr_data_q <= s_wr_data_d;
            s_wr_q      <= s_wr_d;
            s_rd_q      <= s_rd_d;
            pv_q        <= pv_d;
            pm_q        <= pm_d;
            ps_q        <= ps_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    assign bus.s_addr    = s_addr_q;
    assign bus.s_wr_data = s_wr_data_q;
    assign bus.s_wr      = s_wr_q;
    assign bus.s_rd      = s_rd_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.rd_valid  = rd_valid_q;
endmodule

// File: tb/tb_bridge_decode.sv
// tb/tb_bridge_decode.sv - scoreboard bench for bridge_decode (two parameter sets)
module tb_bridge_decode;
    logic clk = 1'b0;
    logic reset_n = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bridge_decode_if #(.NUM_SLAVES(4)) bus0 ();
    bridge_decode_if #(.NUM_SLAVES(3)) bus1 ();

    bridge_decode #(.NUM_SLAVES(4), .SEL_LSB(24), .SEL_W(2), .RD_LATENCY(1),
                    .DEFAULT_DATA(32'hDEAD_BEEF))
        dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0.slave));

    bridge_decode #(.NUM_SLAVES(3), .SEL_LSB(24), .SEL_W(2), .RD_LATENCY(3),
                    .DEFAULT_DATA(32'hDEAD_BEEF))
        dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1.slave));

    // Slave word for slave i at address a: per-slave base XOR low address bits.
    logic [31:0] tab [4];

    // Slave models: capture s_addr and present data RD_LATENCY cycles later.
    logic [31:0] dl0;
    logic [31:0] dl1 [3];

    always @(posedge clk) begin
        dl0    <= bus0.s_addr;
        dl1[0] <= bus1.s_addr;
        dl1[1] <= dl1[0];
        dl1[2] <= dl1[1];
    end

    always_comb begin
        bus0.s_rd_data = '0;
        bus1.s_rd_data = '0;
        for (int i = 0; i < 4; i++) bus0.s_rd_data[32*i +: 32] = tab[i] ^ {8'h0, dl0[23:0]};
        for (int i = 0; i < 3; i++) bus1.s_rd_data[32*i +: 32] = tab[i] ^ {8'h0, dl1[2][23:0]};
    end

    typedef struct {
        int          cyc;
        logic        rst;
        logic [31:0] a;
        logic [31:0] d;
        logic        wr;
        logic        rd;
    } req_t;

    typedef struct {
        int          due;
        logic [31:0] data;
    } rexp_t;

    req_t        req [$];
    rexp_t       rq  [2][$];
    logic [31:0] last [2];
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic int nsl(input int k);
        return (k == 0) ? 4 : 3;
    endfunction

    function automatic int lat(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic logic [31:0] exp_oh(input logic [31:0] a, input logic s, input int n);
        logic [1:0] sl;
        sl = a[25:24];
        if (s && int'(sl) < n) return 32'd1 << sl;
        return 32'd0;
    endfunction

    task automatic drive(input logic rst, input logic [31:0] a, input logic w,
                         input logic r, input logic [31:0] wd);
        req_t  q;
        rexp_t e;
        @(posedge clk);
        #1;
        reset_n = rst;
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                rq[k].delete();
                last[k] = 32'd0;
            end
        end
        bus0.addr = a; bus0.wr = w; bus0.rd = r; bus0.wr_data = wd;
        bus1.addr = a; bus1.wr = w; bus1.rd = r; bus1.wr_data = wd;
        q.cyc = cyc; q.rst = rst; q.a = a; q.d = wd; q.wr = w; q.rd = r;
        req.push_back(q);
        if (rst && r) begin
            for (int k = 0; k < 2; k++) begin
                e.due  = cyc + lat(k) + 2;
                e.data = (int'(a[25:24]) < nsl(k)) ? (tab[a[25:24]] ^ {8'h0, a[23:0]})
                                                   : 32'hDEAD_BEEF;
                rq[k].push_back(e);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, $urandom, 1'b0, 1'b0, $urandom);
    endtask

    task automatic check_rd(input int k, input logic v, input logic [31:0] d);
        rexp_t e;
        if (v) begin
            if (rq[k].size() == 0) begin
                chk($sformatf("unexpected_rd_valid%0d", k), {31'd0, v}, 32'd0);
            end else begin
                e = rq[k].pop_front();
                chk($sformatf("rd_latency%0d", k), cyc, e.due);
                chk($sformatf("rd_data%0d", k), d, e.data);
                last[k] = e.data;
            end
        end else begin
            chk($sformatf("rd_data_hold%0d", k), d, last[k]);
            if (rq[k].size() != 0 && rq[k][0].due <= cyc) begin
                e = rq[k].pop_front();
                chk($sformatf("missing_rd_valid%0d", k), {31'd0, v}, 32'd1);
            end
        end
    endtask

    // Monitor: checks every cycle away from the active edge.
    initial begin
        req_t r;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                chk("rst_rd_data0", bus0.rd_data, 0);     chk("rst_rd_data1", bus1.rd_data, 0);
                chk("rst_rd_valid0", 32'(bus0.rd_valid), 0); chk("rst_rd_valid1", 32'(bus1.rd_valid), 0);
                chk("rst_s_addr0", bus0.s_addr, 0);       chk("rst_s_addr1", bus1.s_addr, 0);
                chk("rst_s_wr_data0", bus0.s_wr_data, 0); chk("rst_s_wr_data1", bus1.s_wr_data, 0);
                chk("rst_s_wr0", 32'(bus0.s_wr), 0);      chk("rst_s_wr1", 32'(bus1.s_wr), 0);
                chk("rst_s_rd0", 32'(bus0.s_rd), 0);      chk("rst_s_rd1", 32'(bus1.s_rd), 0);
                last[0] = 32'd0;
                last[1] = 32'd0;
            end else begin
                while (req.size() != 0 && req[0].cyc < cyc - 1) void'(req.pop_front());
                if (req.size() != 0 && req[0].cyc == cyc - 1) begin
                    r = req.pop_front();
                    chk("s_addr0",    bus0.s_addr,    r.rst ? r.a : 32'd0);
                    chk("s_addr1",    bus1.s_addr,    r.rst ? r.a : 32'd0);
                    chk("s_wr_data0", bus0.s_wr_data, r.rst ? r.d : 32'd0);
                    chk("s_wr_data1", bus1.s_wr_data, r.rst ? r.d : 32'd0);
                    chk("s_wr0", 32'(bus0.s_wr), exp_oh(r.a, r.rst && r.wr, 4));
                    chk("s_wr1", 32'(bus1.s_wr), exp_oh(r.a, r.rst && r.wr, 3));
                    chk("s_rd0", 32'(bus0.s_rd), exp_oh(r.a, r.rst && r.rd, 4));
                    chk("s_rd1", 32'(bus1.s_rd), exp_oh(r.a, r.rst && r.rd, 3));
                end
                check_rd(0, bus0.rd_valid, bus0.rd_data);
                check_rd(1, bus1.rd_valid, bus1.rd_data);
            end
        end
    end

    initial begin
        logic [31:0] a;
        logic        r;
        logic        w;
        int          rlen;

        last[0] = 32'd0;
        last[1] = 32'd0;
        tab[0] = 32'h0000_000A;
        tab[1] = 32'h2024_0315;
        tab[2] = 32'h0000_000B;
        tab[3] = 32'h0000_000C;
        bus0.addr = '0; bus0.wr = 1'b0; bus0.rd = 1'b1; bus0.wr_data = '0;
        bus1.addr = '0; bus1.wr = 1'b0; bus1.rd = 1'b1; bus1.wr_data = '0;
        #1 reset_n = 1'b0;

        // Reset held with rd asserted, then the first sampled read to slave 1.
        for (int i = 0; i < 3; i++) drive(1'b0, 32'h0100_0000, 1'b0, 1'b1, 32'h0);
        drive(1'b1, 32'h0100_0000, 1'b0, 1'b1, 32'h0);
        idle(7);

        // Single read to slave 1, then hold.
        drive(1'b1, 32'h0100_0000, 1'b0, 1'b1, 32'h0);
        idle(7);

        // Back-to-back reads to slaves 0, 2, 3 (3 is unmapped on the 3-slave decoder).
        drive(1'b1, 32'h0000_0000, 1'b0, 1'b1, 32'h0);
        drive(1'b1, 32'h0200_0000, 1'b0, 1'b1, 32'h0);
        drive(1'b1, 32'h0300_0000, 1'b0, 1'b1, 32'h0);
        idle(7);

        // Write to slave 2, then read and write together.
        drive(1'b1, 32'h0200_0008, 1'b1, 1'b0, 32'h1234_5678);
        idle(4);
        drive(1'b1, 32'h0100_0004, 1'b1, 1'b1, 32'h0BAD_F00D);
        idle(7);

        // Reset mid-flight: read at cycle 0, reset asserted at cycle 2.
        drive(1'b1, 32'h0200_0010, 1'b0, 1'b1, 32'h0);
        drive(1'b1, 32'h0000_0000, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'h0);
        idle(10);

        // Randomized traffic with fresh slave contents and occasional resets.
        for (int i = 0; i < 4; i++) tab[i] = $urandom;
        for (int i = 0; i < 600; i++) begin
            a = $urandom;
            r = ($urandom_range(0, 99) < 55);
            w = ($urandom_range(0, 99) < 30);
            if ($urandom_range(0, 199) == 0) begin
                rlen = $urandom_range(1, 3);
                for (int j = 0; j < rlen; j++) drive(1'b0, a, w, r, $urandom);
            end else begin
                drive(1'b1, a, w, r, $urandom);
            end
        end
        idle(10);

        chk("drain0", rq[0].size(), 0);
        chk("drain1", rq[1].size(), 0);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bridge_decode.md
Name: bridge_decode

Overview:
- Address decoder and read-data return mux between the host bridge port and a set of bridge slaves (ID block, config registers, and similar).
- Registers the host address, write data and strobes, then fans them out to one slave selected by an address field.
- Tracks each outstanding read through a latency-matched pipeline and returns the selected slave's data with a `rd_valid` pulse.
- Unmapped selects return a fixed default word.

Parameters:
- NUM_SLAVES, 4, number of attached slaves (1..2**SEL_W).
- SEL_LSB, 24, LSB of the slave-select field in `addr`.
- SEL_W, 2, width of the slave-select field.
- RD_LATENCY, 1, cycles from slave `s_rd` strobe to valid `s_rd_data` (1..4), identical for all slaves.
- DEFAULT_DATA, 32'hDEAD_BEEF, read data returned for unmapped selects.

Ports:
- clk  in  1  bridge clock; all logic in this single domain.
- reset_n  in  1  asynchronous, active-low reset.
- addr  in  32  host byte address.
- wr  in  1  host write strobe, one cycle per write.
- rd  in  1  host read strobe, one cycle per read.
- wr_data  in  32  host write data.
- rd_data  out  32  returned read data, held between reads.
- rd_valid  out  1  one-cycle pulse; `rd_data` updated this cycle.
- s_addr  out  32  registered `addr`, common to all slaves.
- s_wr_data  out  32  registered `wr_data`, common to all slaves.
- s_wr  out  NUM_SLAVES  one-hot registered write strobe.
- s_rd  out  NUM_SLAVES  one-hot registered read strobe.
- s_rd_data  in  32*NUM_SLAVES  slave read data; slave i occupies bits [32*i +: 32].

Behaviour:
- Reset (async assert, sync release):
  - `rd_data`=0, `rd_valid`=0, `s_addr`=0, `s_wr_data`=0, `s_wr`=0, `s_rd`=0.
  - All pipeline valid bits cleared.
- Decode: `sel = addr[SEL_LSB +: SEL_W]`. The select is mapped when `sel < NUM_SLAVES`.
- Request stage, cycle 0 to cycle 1:
  - Every cycle, `s_addr <= addr` and `s_wr_data <= wr_data`.
  - `s_wr[i] <= wr && mapped && sel==i`; `s_rd[i] <= rd && mapped && sel==i`.
  - Strobes last exactly one cycle.
  - An unmapped write is dropped silently.
  - An unmapped read raises no `s_rd` but still enters the return pipeline.
- Return pipeline:
  - On `rd` at cycle 0, push {valid=1, mapped, sel} into a shift register of depth 1+RD_LATENCY.
  - An entry exits at cycle 1+RD_LATENCY.
  - At the next edge (cycle 2+RD_LATENCY), `rd_data` loads `s_rd_data[sel]` if mapped, else DEFAULT_DATA, and `rd_valid` pulses.
  - Total host read latency is RD_LATENCY+2 cycles (3 at default).
- Throughput:
  - One read per cycle is sustained with no gaps.
  - Back-to-back reads to different slaves return in issue order, one `rd_valid` per read.
- No read in flight: `rd_valid`=0 and `rd_data` holds its last value.
- Simultaneous `rd` and `wr` in one cycle:
  - Both are forwarded to the decoded slave in the same cycle (`s_rd[i]` and `s_wr[i]` both high).
  - The read is tracked normally.
  - The slave defines read-during-write ordering.
- Writes never produce `rd_valid`.
- Reset mid-operation: all in-flight reads are discarded; no `rd_valid` follows reset release until a new `rd` is issued.
- Read-data width is fixed at 32. Address bits outside the select field pass through unchanged in `s_addr`; the slave decodes its own word offset, e.g. `addr[3:2]`.

Test Plan:
- Reset release:
  - Stimulus: `reset_n` low for 3 cycles with `rd`=1 held.
  - Response: while low, all outputs 0; after release, the first `rd_valid` occurs exactly 3 cycles after the first sampled `rd`.
- Single read:
  - Stimulus: slave 1 drives `s_rd_data` = 32'h2024_0315; `rd` with `addr` = 32'h0100_0000 at cycle 0.
  - Response: `s_rd` = 4'b0010 at cycle 1; `rd_data` = 32'h2024_0315 with `rd_valid`=1 at cycle 3; `rd_valid`=0 at cycle 4 and `rd_data` held.
- Back-to-back reads:
  - Stimulus: reads to `sel` = 0, 2, 3 on consecutive cycles; slaves return 32'hA, 32'hB, 32'hC.
  - Response: `rd_valid` high at cycles 3, 4, 5 with `rd_data` A, B, C in order.
- Unmapped read, with NUM_SLAVES=3:
  - Stimulus: read at `addr` = 32'h0300_0000.
  - Response: `s_rd` stays 0; `rd_data` = 32'hDEAD_BEEF with `rd_valid` at cycle 3.
- Write:
  - Stimulus: `wr` at `addr` = 32'h0200_0008, `wr_data` = 32'h1234_5678.
  - Response: at cycle 1, `s_wr` = 4'b0100, `s_addr` = 32'h0200_0008, `s_wr_data` = 32'h1234_5678; no `rd_valid`.
- Reset mid-flight, with RD_LATENCY=3:
  - Stimulus: issue a read, then assert `reset_n` low at cycle 2.
  - Response: no `rd_valid` at any time; `rd_data` = 0 after reset.
